// File: rtl/vpu_fp_minmax_reduce_pkg.sv
// Shared BF16 definitions for the VPU float min/max reduction unit.
// Optional build macro VPU_FP_MINMAX_NAN_PROP_EN enables NaN propagation
// in the select datapath (see vpu_bf16_minmax_sel).
package vpu_fp_minmax_reduce_pkg;

    localparam int BF16_WIDTH    = 16;
    localparam int BF16_EXP_MSB  = 14;
    localparam int BF16_EXP_LSB  = 7;
    localparam int BF16_MANT_MSB = 6;

    localparam logic [BF16_WIDTH-1:0] BF16_QNAN = 16'h7FC0;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

    typedef enum logic {
        MINMAX_MAX = 1'b0,
        MINMAX_MIN = 1'b1
    } minmax_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Maps a BF16 bit pattern onto an unsigned key whose natural order is the
    // total order of the unit: positives above negatives, +0 above -0, and
    // negatives ordered by inverted magnitude.
    function automatic logic [BF16_WIDTH-1:0] bf16_order_key(input bf16_t v);
        if (v.sign) begin
            return {1'b0, ~{v.exp, v.mant}};
        end else begin
            return {1'b1, v.exp, v.mant};
        end
    endfunction

    // True for any NaN pattern (all-ones exponent, non-zero mantissa).
    function automatic logic bf16_is_nan(input logic [BF16_WIDTH-1:0] v);
        return (v[BF16_EXP_MSB:BF16_EXP_LSB] == 8'hFF) &&
               (v[BF16_MANT_MSB:0] != 7'd0);
    endfunction

endpackage

// File: rtl/vpu_bf16_minmax_sel.sv
// Combinational two-operand BF16 min/max select with per-operand valid.
// Operand a has tie priority; with neither operand valid the output is zero.
// With VPU_FP_MINMAX_NAN_PROP_EN defined, a NaN on any valid operand forces
// the canonical quiet NaN.
module vpu_bf16_minmax_sel
    import vpu_fp_minmax_reduce_pkg::*;
(
    input  logic [BF16_WIDTH-1:0] a,
    input  logic                  a_valid,
    input  logic [BF16_WIDTH-1:0] b,
    input  logic                  b_valid,
    input  minmax_mode_t          mode,
    output logic [BF16_WIDTH-1:0] y
);

    logic [BF16_WIDTH-1:0] key_a_s;
    logic [BF16_WIDTH-1:0] key_b_s;
    logic                  b_wins_s;
    logic [BF16_WIDTH-1:0] pick_s;

    // Order both operands and pick the winner; b wins only on a strict compare.
    always_comb begin
        key_a_s = bf16_order_key(a);
        key_b_s = bf16_order_key(b);
        if (mode == MINMAX_MIN) begin
            b_wins_s = (key_b_s < key_a_s);
        end else begin
            b_wins_s = (key_b_s > key_a_s);
        end
        if (a_valid && b_valid) begin
            pick_s = b_wins_s ? b : a;
        end else if (a_valid) begin
            pick_s = a;
        end else if (b_valid) begin
            pick_s = b;
        end else begin
            pick_s = 16'h0000;
        end
    end

`ifdef VPU_FP_MINMAX_NAN_PROP_EN
    logic nan_s;

    // Any valid NaN operand overrides the ordered pick.
    always_comb begin
        nan_s = (a_valid && bf16_is_nan(a)) || (b_valid && bf16_is_nan(b));
        if (nan_s) begin
            y = BF16_QNAN;
        end else begin
            y = pick_s;
        end
    end
`else
    // NaN patterns are ordered like any other value.
    always_comb begin
        y = pick_s;
    end
`endif

endmodule

// File: rtl/vpu_fp_minmax_reduce.sv
// Pipelined BF16 min/max reduction: S1 selects across valid sources per lane,
// S2 accumulates across beats of a group, result held until consumed.
// Optional build macro: VPU_FP_MINMAX_NAN_PROP_EN (NaN propagation).
module vpu_fp_minmax_reduce
    import vpu_fp_minmax_reduce_pkg::*;
#(
    parameter int LANE_CNT   = 16,
    parameter int SRC_CNT    = 3,
    parameter int ELEM_WIDTH = BF16_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [SRC_CNT-1:0][LANE_CNT*ELEM_WIDTH-1:0] op_i,
    input  logic [SRC_CNT-1:0]                      op_valid,
    input  logic                                    mode,
    input  logic                                    last,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [LANE_CNT*ELEM_WIDTH-1:0]          result_o
);

    localparam int VEC_W = LANE_CNT * ELEM_WIDTH;

    // Input-side group tracking
    logic          in_group_r;
    minmax_mode_t  group_mode_r;
    logic          accept_s;
    logic          first_beat_s;
    minmax_mode_t  beat_mode_s;

    // S1 datapath
    logic [SRC_CNT-1:0]    prefix_any_s;
    logic [ELEM_WIDTH-1:0] chain_s [LANE_CNT][SRC_CNT];
    logic [VEC_W-1:0]      sel_vec_s;
    logic                  s1_valid_r;
    logic [VEC_W-1:0]      s1_val_r;
    logic                  s1_any_r;
    logic                  s1_last_r;
    logic                  s1_first_r;
    minmax_mode_t          s1_mode_r;

    // S2 accumulator and output
    logic [VEC_W-1:0] acc_r;
    logic             acc_any_r;
    logic             acc_live_s;
    logic [VEC_W-1:0] acc_next_s;
    state_t           state_r;
    logic             out_valid_r;
    logic [VEC_W-1:0] result_r;

    assign accept_s     = in_valid & in_ready;
    assign first_beat_s = ~in_group_r;
    assign acc_live_s   = acc_any_r & ~s1_first_r;

    // Stall intake while the result is held or a last beat is still in S1.
    assign in_ready  = ~rst & (state_r != HOLD) & ~(s1_valid_r & s1_last_r);
    assign out_valid = out_valid_r;
    assign result_o  = result_r;

    // Later beats of a group use the mode captured on the first beat.
    always_comb begin
        if (first_beat_s) begin
            beat_mode_s = minmax_mode_t'(mode);
        end else begin
            beat_mode_s = group_mode_r;
        end
    end

    // prefix_any_s[s] is set when any source 0..s is valid.
    assign prefix_any_s[0] = op_valid[0];
    for (genvar s = 1; s < SRC_CNT; s++) begin : g_prefix
        assign prefix_any_s[s] = prefix_any_s[s-1] | op_valid[s];
    end

    for (genvar l = 0; l < LANE_CNT; l++) begin : g_lane
        // Left-to-right fold keeps the lower source index on ties.
        assign chain_s[l][0] = op_i[0][l*ELEM_WIDTH +: ELEM_WIDTH];
        for (genvar s = 1; s < SRC_CNT; s++) begin : g_src
            vpu_bf16_minmax_sel u_src_sel (
                .a       (chain_s[l][s-1]),
                .a_valid (prefix_any_s[s-1]),
                .b       (op_i[s][l*ELEM_WIDTH +: ELEM_WIDTH]),
                .b_valid (op_valid[s]),
                .mode    (beat_mode_s),
                .y       (chain_s[l][s])
            );
        end
        assign sel_vec_s[l*ELEM_WIDTH +: ELEM_WIDTH] = chain_s[l][SRC_CNT-1];

        // Accumulator sits on the a side so it wins ties against the beat.
        vpu_bf16_minmax_sel u_acc_sel (
            .a       (acc_r[l*ELEM_WIDTH +: ELEM_WIDTH]),
            .a_valid (acc_live_s),
            .b       (s1_val_r[l*ELEM_WIDTH +: ELEM_WIDTH]),
            .b_valid (s1_any_r),
            .mode    (s1_mode_r),
            .y       (acc_next_s[l*ELEM_WIDTH +: ELEM_WIDTH])
        );
    end

    // Track whether the next accepted beat opens a group and latch its mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_group_r   <= 1'b0;
            group_mode_r <= MINMAX_MAX;
        end else begin
            if (accept_s) begin
                in_group_r <= ~last;
                if (first_beat_s) begin
                    group_mode_r <= minmax_mode_t'(mode);
                end
            end
        end
    end

    // S1 register: per-lane source select plus beat sideband.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_val_r   <= '0;
            s1_any_r   <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_first_r <= 1'b0;
            s1_mode_r  <= MINMAX_MAX;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_val_r   <= sel_vec_s;
                s1_any_r   <= prefix_any_s[SRC_CNT-1];
                s1_last_r  <= last;
                s1_first_r <= first_beat_s;
                s1_mode_r  <= beat_mode_s;
            end
        end
    end

    // S2 accumulator and group FSM with registered result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= '0;
            acc_any_r   <= 1'b0;
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            result_r    <= '0;
        end else begin
            if (s1_valid_r) begin
                acc_r     <= acc_next_s;
                acc_any_r <= acc_live_s | s1_any_r;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= ACC;
                    end
                end
                ACC: begin
                    if (s1_valid_r && s1_last_r) begin
                        state_r     <= HOLD;
                        out_valid_r <= 1'b1;
                        result_r    <= acc_next_s;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_fp_minmax_reduce.sv
// Scoreboard bench for vpu_fp_minmax_reduce: directed groups push expected
// vectors; a negedge monitor pops and compares on every output handshake.
module tb_vpu_fp_minmax_reduce;

    localparam int LANES = 16;
    localparam int SRCS  = 3;
    localparam int EW    = 16;
    localparam int VW    = LANES * EW;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [SRCS-1:0][VW-1:0]  op_i;
    logic [SRCS-1:0]          op_valid;
    logic                     mode;
    logic                     last;
    logic                     out_valid;
    logic                     out_ready;
    logic [VW-1:0]            result_o;

    int            tests = 0;
    int            fails = 0;
    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] mon_exp;

    vpu_fp_minmax_reduce #(
        .LANE_CNT   (LANES),
        .SRC_CNT    (SRCS),
        .ELEM_WIDTH (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_i      (op_i),
        .op_valid  (op_valid),
        .mode      (mode),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] rep(input logic [15:0] x);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*EW +: EW] = x;
        return r;
    endfunction

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    // Monitor: every accepted output is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %h required none", result_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check_vec("scoreboard", result_o, mon_exp);
            end
        end
    end

    task automatic send_beat(input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                             input logic [VW-1:0] v2, input logic [2:0] vld,
                             input logic md, input logic lst, output int waited);
        waited = 0;
        @(negedge clk);
        op_i[0]  = v0;
        op_i[1]  = v1;
        op_i[2]  = v2;
        op_valid = vld;
        mode     = md;
        last     = lst;
        in_valid = 1'b1;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got 0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        logic [VW-1:0] v0, v1, v2, e;
        int w, n;

        rst = 1'b1; in_valid = 1'b0; op_i = '0; op_valid = 3'b000;
        mode = 1'b0; last = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_vec("rst_result", result_o, {VW{1'b0}});
        check_bit("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check_bit("post_rst_in_ready", in_ready, 1'b1);

        // Single beat, max, three valid sources; lane 5 won by source 2
        v0 = rep(16'h3F80); v1 = rep(16'h4000); v2 = rep(16'hC000);
        v2[5*EW +: EW] = 16'h4100;
        e = rep(16'h4000); e[5*EW +: EW] = 16'h4100;
        exp_q.push_back(e);
        send_beat(v0, v1, v2, 3'b111, 1'b0, 1'b1, w);
        @(negedge clk);
        check_bit("latency_t1", out_valid, 1'b0);
        check_bit("in_ready_s1_last", in_ready, 1'b0);
        @(negedge clk);
        check_bit("latency_t2", out_valid, 1'b1);
        drain();

        // Negative-only, source 2 invalid: min then max
        v0 = rep(16'hBF80); v1 = rep(16'hC040); v2 = rep(16'h7F80);
        exp_q.push_back(rep(16'hC040));
        send_beat(v0, v1, v2, 3'b011, 1'b1, 1'b1, w);
        exp_q.push_back(rep(16'hBF80));
        send_beat(v0, v1, v2, 3'b011, 1'b0, 1'b1, w);
        drain();

        // Four-beat max group, mode toggled on beat 2, back-to-back beats
        v1 = rep(16'h7F7F); v2 = rep(16'h7F7F);
        exp_q.push_back(rep(16'h40A0));
        send_beat(rep(16'h3F80), v1, v2, 3'b001, 1'b0, 1'b0, w);
        send_beat(rep(16'h40A0), v1, v2, 3'b001, 1'b1, 1'b0, w);
        check_bit("in_ready_beat2", (w == 0), 1'b1);
        send_beat(rep(16'hC0E0), v1, v2, 3'b001, 1'b0, 1'b0, w);
        check_bit("in_ready_beat3", (w == 0), 1'b1);
        send_beat(rep(16'h4040), v1, v2, 3'b001, 1'b0, 1'b1, w);
        check_bit("in_ready_beat4", (w == 0), 1'b1);
        drain();

        // Backpressure: result held stable, intake stalled
        out_ready = 1'b0;
        v0 = rep(16'hC000); v0[7*EW +: EW] = 16'h3C00;
        v1 = rep(16'hBF80);
        v2 = rep(16'hC100); v2[7*EW +: EW] = 16'h4000;
        e = rep(16'hC100); e[7*EW +: EW] = 16'hBF80;
        exp_q.push_back(e);
        send_beat(v0, v1, v2, 3'b111, 1'b1, 1'b1, w);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_bit("bp_out_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("bp_out_valid_hold", out_valid, 1'b1);
            check_vec("bp_result_stable", result_o, e);
            check_bit("bp_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(rep(16'h3F80));
        send_beat(rep(16'h3F80), rep(16'h3F00), rep(16'h3F00), 3'b111, 1'b0, 1'b1, w);
        drain();

        // Signed zeros, empty group, empty leading beat
        exp_q.push_back(rep(16'h0000));
        send_beat(rep(16'h8000), rep(16'h0000), rep(16'h0000), 3'b011, 1'b0, 1'b1, w);
        exp_q.push_back(rep(16'h8000));
        send_beat(rep(16'h8000), rep(16'h0000), rep(16'h0000), 3'b011, 1'b1, 1'b1, w);
        exp_q.push_back(rep(16'h0000));
        send_beat(rep(16'h4000), rep(16'h4100), rep(16'hC000), 3'b000, 1'b0, 1'b1, w);
        exp_q.push_back(rep(16'hC040));
        send_beat(rep(16'h4000), rep(16'h4000), rep(16'h4000), 3'b000, 1'b0, 1'b0, w);
        send_beat(rep(16'hC040), rep(16'h4000), rep(16'h4000), 3'b001, 1'b0, 1'b1, w);
        drain();

        // Reset mid-group discards the partial result
        send_beat(rep(16'h7000), rep(16'h7000), rep(16'h7000), 3'b111, 1'b0, 1'b0, w);
        send_beat(rep(16'h7000), rep(16'h7000), rep(16'h7000), 3'b111, 1'b0, 1'b0, w);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_bit("mid_rst_out_valid", out_valid, 1'b0);
        end
        rst = 1'b0;
        exp_q.push_back(rep(16'h3F80));
        send_beat(rep(16'h3F80), rep(16'h3F00), rep(16'hBF80), 3'b111, 1'b0, 1'b1, w);
        drain();

        // NaN handling in a source lane and in the accumulator
`ifdef VPU_FP_MINMAX_NAN_PROP_EN
        e = rep(16'h3F80); e[3*EW +: EW] = 16'h7FC0;
`else
        e = rep(16'h3F80); e[3*EW +: EW] = 16'h7FC1;
`endif
        v1 = rep(16'h3F00); v1[3*EW +: EW] = 16'h7FC1;
        exp_q.push_back(e);
        send_beat(rep(16'h3F80), v1, rep(16'hBF80), 3'b111, 1'b0, 1'b1, w);
        exp_q.push_back(e);
        send_beat(rep(16'h3F80), v1, rep(16'hBF80), 3'b111, 1'b0, 1'b0, w);
        v0 = rep(16'h3C00); v0[3*EW +: EW] = 16'h4000;
        send_beat(v0, rep(16'h3C00), rep(16'h3C00), 3'b111, 1'b0, 1'b1, w);
        drain();

        check_bit("queue_empty", (exp_q.size() == 0), 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
